// File: rtl/cache_tag_lookup.sv
// Set-associative tag/valid store with 2-stage lookup/fill pipeline feeding the LRU; results 1 cycle after request.
// No backpressure: one lookup and one fill accepted every cycle. Optional invalidate port under CACHE_TAG_INVALIDATE_EN.
module cache_tag_lookup #(
   parameter int NUM_SETS  = 64,
   parameter int NUM_WAYS  = 4,
   parameter int TAG_WIDTH = 20,
   localparam int SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
   localparam int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       lookup_en,
   input  logic [SET_INDEX_WIDTH-1:0] lookup_set,
   input  logic [TAG_WIDTH-1:0]       lookup_tag,
   output logic                       lookup_valid,
   output logic                       lookup_hit,
   output logic [WAY_INDEX_WIDTH-1:0] lookup_way,
   input  logic                       fill_en,
   input  logic [SET_INDEX_WIDTH-1:0] fill_set,
   input  logic [TAG_WIDTH-1:0]       fill_tag,
   output logic                       fill_done,
   output logic [WAY_INDEX_WIDTH-1:0] fill_way,
`ifdef CACHE_TAG_INVALIDATE_EN
   input  logic                       inv_en,
   input  logic [SET_INDEX_WIDTH-1:0] inv_set,
   input  logic [WAY_INDEX_WIDTH-1:0] inv_way,
`endif
   output logic                       lru_access_en,
   output logic [SET_INDEX_WIDTH-1:0] lru_access_set,
   output logic                       lru_update_en,
   output logic [WAY_INDEX_WIDTH-1:0] lru_update_way,
   output logic                       lru_fill_en,
   output logic [SET_INDEX_WIDTH-1:0] lru_fill_set,
   input  logic [WAY_INDEX_WIDTH-1:0] lru_fill_way
);

   logic [TAG_WIDTH-1:0] tag_mem   [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0]  valid_mem [NUM_SETS];

   logic [SET_INDEX_WIDTH-1:0] s1_lookup_set;
   logic [TAG_WIDTH-1:0]       s1_lookup_tag;
   logic [SET_INDEX_WIDTH-1:0] s1_fill_set;
   logic [TAG_WIDTH-1:0]       s1_fill_tag;

   logic                       hit_c;
   logic [WAY_INDEX_WIDTH-1:0] way_c;

   assign lru_access_en  = lookup_en;
   assign lru_access_set = lookup_set;
   assign lru_fill_en    = fill_en;
   assign lru_fill_set   = fill_set;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lookup_valid  <= 1'b0;
         fill_done     <= 1'b0;
         s1_lookup_set <= '0;
         s1_lookup_tag <= '0;
         s1_fill_set   <= '0;
         s1_fill_tag   <= '0;
      end else begin
         lookup_valid  <= lookup_en;
         fill_done     <= fill_en;
         s1_lookup_set <= lookup_set;
         s1_lookup_tag <= lookup_tag;
         s1_fill_set   <= fill_set;
         s1_fill_tag   <= fill_tag;
      end
   end

   // Descending scan so the lowest matching way is the one that sticks.
   always_comb begin
      hit_c = 1'b0;
      way_c = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_mem[s1_lookup_set][w] && (tag_mem[s1_lookup_set][w] == s1_lookup_tag)) begin
            hit_c = 1'b1;
            way_c = WAY_INDEX_WIDTH'(w);
         end
      end
   end

   assign lookup_hit     = lookup_valid & hit_c;
   assign lookup_way     = lookup_hit ? way_c : '0;
   assign fill_way       = fill_done ? lru_fill_way : '0;
   // A fill completing this cycle takes precedence in the LRU over a hit promotion.
   assign lru_update_en  = lookup_valid & lookup_hit & ~fill_done;
   assign lru_update_way = lookup_way;

   // fill_done is async-cleared, so a reset mid-fill also blocks the tag write.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_mem[s1_fill_set][lru_fill_way] <= s1_fill_tag;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_mem[s] <= '0;
         end
      end else begin
`ifdef CACHE_TAG_INVALIDATE_EN
         if (inv_en) begin
            valid_mem[inv_set][inv_way] <= 1'b0;
         end
`endif
         if (fill_done) begin
            valid_mem[s1_fill_set][lru_fill_way] <= 1'b1;
         end
      end
   end

endmodule
